// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: turns CMD / ADDR (MSB first) / DATA byte frames from the
// receiver into single req/ack bus transactions, flagging bad commands, timeouts and overruns.
module uart_cmd_ctrl #(
   parameter int unsigned              DATA_WIDTH     = 8,
   parameter int unsigned              ADDR_BYTES     = 2,
   parameter int unsigned              TIMEOUT_CYCLES = 2048,
   parameter logic [DATA_WIDTH-1:0]    CMD_WR         = 8'h57,
   parameter logic [DATA_WIDTH-1:0]    CMD_RD         = 8'h52
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               rx_ready,
   input  logic [DATA_WIDTH-1:0]              rx_data,
   output logic                               bus_req,
   output logic                               bus_wr,
   output logic [ADDR_BYTES*DATA_WIDTH-1:0]   bus_addr,
   output logic [DATA_WIDTH-1:0]              bus_wdata,
   input  logic                               bus_ack,
   output logic                               busy,
   output logic                               frame_err,
   output logic                               overrun
);

   localparam int unsigned AW = ADDR_BYTES * DATA_WIDTH;
   localparam int unsigned CW = $clog2(ADDR_BYTES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_CMD   = 2'd0,
      S_ADDR  = 2'd1,
      S_WDATA = 2'd2,
      S_REQ   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    rx_ready_q;
   logic                    wr_q, wr_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic [AW-1:0]           addr_sh_q, addr_sh_d;
   logic                    bus_req_q, bus_req_d;
   logic                    bus_wr_q, bus_wr_d;
   logic [AW-1:0]           bus_addr_q, bus_addr_d;
   logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
   logic                    busy_q;
   logic                    frame_err_q, frame_err_d;
   logic                    overrun_q, overrun_d;
   logic                    byte_stb;
   logic                    tmo_hit;

   // One strobe per rising edge of the receiver's level-type ready.
   assign byte_stb = rx_ready & ~rx_ready_q;
   assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_CMD;
         rx_ready_q  <= 1'b0;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         addr_sh_q   <= '0;
         bus_req_q   <= 1'b0;
         bus_wr_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_ready_q  <= rx_ready;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         addr_sh_q   <= addr_sh_d;
         bus_req_q   <= bus_req_d;
         bus_wr_q    <= bus_wr_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         busy_q      <= (state_d != S_CMD);
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      addr_sh_d   = addr_sh_q;
      bus_req_d   = bus_req_q;
      bus_wr_d    = bus_wr_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
         S_CMD: begin
            if (byte_stb) begin
               if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                  wr_d      = (rx_data == CMD_WR);
                  cnt_d     = '0;
                  tmo_d     = '0;
                  addr_sh_d = '0;
                  state_d   = S_ADDR;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end

         S_ADDR: begin
            if (byte_stb) begin
               addr_sh_d = AW'({addr_sh_q, rx_data});
               cnt_d     = cnt_q + CW'(1);
               tmo_d     = '0;
               if (cnt_q == CW'(ADDR_BYTES - 1)) begin
                  if (wr_q) begin
                     state_d = S_WDATA;
                  end else begin
                     bus_req_d   = 1'b1;
                     bus_wr_d    = 1'b0;
                     bus_addr_d  = addr_sh_d;
                     bus_wdata_d = '0;
                     state_d     = S_REQ;
                  end
               end
            end else if (tmo_hit) begin
               frame_err_d = 1'b1;
               cnt_d       = '0;
               tmo_d       = '0;
               addr_sh_d   = '0;
               state_d     = S_CMD;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_WDATA: begin
            if (byte_stb) begin
               bus_req_d   = 1'b1;
               bus_wr_d    = 1'b1;
               bus_addr_d  = addr_sh_q;
               bus_wdata_d = rx_data;
               tmo_d       = '0;
               state_d     = S_REQ;
            end else if (tmo_hit) begin
               frame_err_d = 1'b1;
               cnt_d       = '0;
               tmo_d       = '0;
               addr_sh_d   = '0;
               state_d     = S_CMD;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_REQ: begin
            // Any byte arriving here is dropped, including one coinciding with ack.
            overrun_d = byte_stb;
            if (bus_ack) begin
               bus_req_d = 1'b0;
               state_d   = S_CMD;
            end
         end

         default: begin
            state_d = S_CMD;
         end
      endcase
   end

   assign bus_req   = bus_req_q;
   assign bus_wr    = bus_wr_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Sequences the UART receive datapath into serial-bus transactions.
- Watches the UART receiver's level-type `ready` output and byte output, and assembles command frames of the form CMD, ADDR (MSB first), then DATA for writes only.
- For each complete frame, issues one request to the bus master through a req/ack handshake.
- Detects bad command bytes, inter-byte timeouts and bytes arriving while a request is pending. Read data is returned by a separate TX-side block.

Parameters:
- DATA_WIDTH, 8, width of a UART byte and of bus write data.
- ADDR_BYTES, 2, number of address bytes per frame; bus_addr width is ADDR_BYTES*DATA_WIDTH.
- TIMEOUT_CYCLES, 2048, maximum clk cycles allowed between bytes of one frame.
- CMD_WR, 8'h57, command byte for a write.
- CMD_RD, 8'h52, command byte for a read.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_ready  in  1  receiver ready level; rises once per received byte and stays high until the next start bit.
- rx_data  in  DATA_WIDTH  received byte; valid while rx_ready is high.
- bus_req  out  1  transaction request to the bus master.
- bus_wr  out  1  1 = write, 0 = read; valid while bus_req is high.
- bus_addr  out  ADDR_BYTES*DATA_WIDTH  transaction address.
- bus_wdata  out  DATA_WIDTH  write data; holds 0 for reads.
- bus_ack  in  1  one-cycle completion pulse from the bus master.
- busy  out  1  high whenever state != S_CMD.
- frame_err  out  1  one-cycle pulse: bad command byte or timeout.
- overrun  out  1  one-cycle pulse: byte dropped while in S_REQ.

Behaviour:
- Reset (async, rst=1): every output is 0, state=S_CMD, rx_ready_d=0, byte counter=0, timeout counter=0, address/data shift registers=0. Asserting reset mid-frame or mid-request discards everything; bus_req falls immediately.
- Byte strobe: byte_stb = rx_ready & ~rx_ready_d, where rx_ready_d is rx_ready registered.
  - Exactly one strobe per rising edge of rx_ready; a held-high rx_ready never re-triggers.
  - rx_data is captured in the strobe cycle.
- State S_CMD:
  - On byte_stb with rx_data==CMD_WR or CMD_RD: latch wr flag, clear byte counter and timeout counter, go to S_ADDR.
  - On byte_stb with any other value: frame_err pulses for one cycle; stay in S_CMD.
  - No timeout runs in S_CMD.
- State S_ADDR:
  - Each byte_stb shifts rx_data into the address register (MSB first) and increments the byte counter.
  - On the ADDR_BYTES-th byte: go to S_WDATA if wr=1, otherwise load bus outputs and go to S_REQ.
- State S_WDATA: on byte_stb, latch the data byte, load bus outputs and go to S_REQ.
- Timeout (S_ADDR and S_WDATA only):
  - The counter resets on every byte_stb and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 without a strobe: frame_err pulses, the partial frame is discarded, and state returns to S_CMD.
  - If a strobe and the timeout fall in the same cycle, the strobe wins.
- State S_REQ:
  - bus_req=1 on the first cycle after entering the state (one cycle after the final byte_stb).
  - bus_wr, bus_addr and bus_wdata are stable for the whole time bus_req is high.
  - On the cycle bus_ack=1 is sampled: bus_req goes to 0 on the next edge and state returns to S_CMD. A new frame may start from the following cycle.
  - bus_ack sampled outside S_REQ is ignored.
  - byte_stb in S_REQ: the byte is discarded and overrun pulses for one cycle. A byte_stb in the same cycle as bus_ack is also discarded with an overrun pulse.
- Between requests, bus_addr and bus_wdata hold their last values; bus_wdata is forced to 0 for reads.
- busy is registered alongside state (high in S_ADDR, S_WDATA and S_REQ).
- Error pulses never coincide with a state change into S_REQ.

Test Plan:
- Write frame: bytes 57, 12, 34, AB with bus_ack returned 3 cycles after bus_req rises -> exactly one request with bus_wr=1, bus_addr=16'h1234, bus_wdata=8'hAB. bus_req is high for 4 cycles, then busy=0.
- Read frame: bytes 52, 00, 7F -> bus_req with bus_wr=0, bus_addr=16'h007F, bus_wdata=0. No fourth byte is needed.
- Bad command: byte 8'h41 -> frame_err high for exactly 1 cycle, busy stays 0. A following frame 57,00,01,FF completes normally.
- Timeout: bytes 57, 12, then silence for TIMEOUT_CYCLES -> frame_err pulse, busy=0, no bus_req. Next frame 52,AA,BB -> read with bus_addr=16'hAABB (no stale 8'h12).
- Overrun and held ready: withhold bus_ack, send byte 8'h55 -> overrun pulse, request outputs unchanged. Hold rx_ready high for 1000 cycles -> only one strobe.
- Reset mid-request: assert rst while bus_req=1 -> bus_req, busy and all outputs are 0 asynchronously. After release, a new write frame succeeds.
